uart_rx_fsm: RTL and testbench

UART_RX_FSM -- requirements
Module: uart_rx_fsm

---
 rtl/uart_rx_fsm_if.sv | 32 +++
 rtl/uart_rx_fsm.sv | 110 +++++++++++
 tb/tb_uart_rx_fsm.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_fsm_if.sv
// Control/status bundle between the UART receive FSM and its sampler/checker datapath.
// master = FSM side, slave = datapath (or bench) side.
interface uart_rx_fsm_if;
   logic       RX_IN;
   logic       PAR_EN;
   logic [5:0] Prescale;
   logic       strt_glitch;
   logic       par_err;
   logic       stp_err;
   logic [5:0] edge_cnt;
   logic [3:0] bit_cnt;
   logic       dat_samp_en;
   logic       strt_chk_en;
   logic       deser_en;
   logic       par_chk_en;
   logic       stop_chk_en;
   logic       data_valid;
   logic       frame_err;
   logic       parity_err;

   modport master (
      input  RX_IN, PAR_EN, Prescale, strt_glitch, par_err, stp_err,
      output edge_cnt, bit_cnt, dat_samp_en, strt_chk_en, deser_en,
             par_chk_en, stop_chk_en, data_valid, frame_err, parity_err
   );

   modport slave (
      output RX_IN, PAR_EN, Prescale, strt_glitch, par_err, stp_err,
      input  edge_cnt, bit_cnt, dat_samp_en, strt_chk_en, deser_en,
             par_chk_en, stop_chk_en, data_valid, frame_err, parity_err
   );
endinterface

// File: rtl/uart_rx_fsm.sv
// UART receive sequencer: walks start/data/parity/stop bits at Prescale oversampling and
// issues one-cycle registered strobes; the frame verdict appears one cycle after stop mid+3.
module uart_rx_fsm (
   input logic            CLK,
   input logic            RST,
   uart_rx_fsm_if.master  bus
);
   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

   state_t     state;
   logic       err_flag;
   logic [5:0] half;
   logic [5:0] pre_samp;
   logic [5:0] chk_edge;
   logic [5:0] last_edge;
   logic [5:0] edge_nxt;

   // Strobes are registered, so they are launched one edge early to land on H+2.
   assign half      = {1'b0, bus.Prescale[5:1]};
   assign pre_samp  = half + 6'd1;
   assign chk_edge  = half + 6'd3;
   assign last_edge = bus.Prescale - 6'd1;
   assign edge_nxt  = (bus.edge_cnt == last_edge) ? 6'd0 : bus.edge_cnt + 6'd1;

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state           <= IDLE;
         err_flag        <= 1'b0;
         bus.edge_cnt    <= 6'd0;
         bus.bit_cnt     <= 4'd0;
         bus.dat_samp_en <= 1'b0;
         bus.strt_chk_en <= 1'b0;
         bus.deser_en    <= 1'b0;
         bus.par_chk_en  <= 1'b0;
         bus.stop_chk_en <= 1'b0;
         bus.data_valid  <= 1'b0;
         bus.frame_err   <= 1'b0;
         bus.parity_err  <= 1'b0;
      end else begin
         bus.strt_chk_en <= 1'b0;
         bus.deser_en    <= 1'b0;
         bus.par_chk_en  <= 1'b0;
         bus.stop_chk_en <= 1'b0;
         bus.data_valid  <= 1'b0;
         bus.frame_err   <= 1'b0;
         bus.parity_err  <= 1'b0;
         case (state)
            IDLE: begin
               bus.edge_cnt <= 6'd0;
               bus.bit_cnt  <= 4'd0;
               if (!bus.RX_IN) begin
                  state           <= START;
                  bus.dat_samp_en <= 1'b1;
               end
            end
            START: begin
               bus.edge_cnt    <= edge_nxt;
               bus.strt_chk_en <= (bus.edge_cnt == pre_samp);
               if (bus.edge_cnt == chk_edge && bus.strt_glitch) begin
                  state           <= IDLE;
                  bus.edge_cnt    <= 6'd0;
                  bus.dat_samp_en <= 1'b0;
               end else if (bus.edge_cnt == last_edge) begin
                  state <= DATA;
               end
            end
            DATA: begin
               bus.edge_cnt <= edge_nxt;
               bus.deser_en <= (bus.edge_cnt == pre_samp);
               if (bus.edge_cnt == last_edge) begin
                  if (bus.bit_cnt == 4'd7) begin
                     bus.bit_cnt <= 4'd0;
                     state       <= bus.PAR_EN ? PARITY : STOP;
                  end else begin
                     bus.bit_cnt <= bus.bit_cnt + 4'd1;
                  end
               end
            end
            PARITY: begin
               bus.edge_cnt   <= edge_nxt;
               bus.par_chk_en <= (bus.edge_cnt == pre_samp);
               if (bus.edge_cnt == chk_edge)
                  err_flag <= bus.par_err;
               if (bus.edge_cnt == last_edge)
                  state <= STOP;
            end
            STOP: begin
               bus.edge_cnt    <= edge_nxt;
               bus.stop_chk_en <= (bus.edge_cnt == pre_samp);
               // Leave at mid stop bit so a start bit right behind it is not missed.
               if (bus.edge_cnt == chk_edge) begin
                  state           <= IDLE;
                  bus.edge_cnt    <= 6'd0;
                  bus.dat_samp_en <= 1'b0;
                  bus.data_valid  <= !bus.stp_err && !err_flag;
                  bus.frame_err   <= bus.stp_err;
                  bus.parity_err  <= err_flag;
                  err_flag        <= 1'b0;
               end
            end
            default: begin
               state           <= IDLE;
               bus.edge_cnt    <= 6'd0;
               bus.bit_cnt     <= 4'd0;
               bus.dat_samp_en <= 1'b0;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_uart_rx_fsm.sv
// Directed bench for uart_rx_fsm: a responder plays the checkers, a monitor counts strobes.
module tb_uart_rx_fsm;
   logic clk;
   logic rst;
   uart_rx_fsm_if bus ();

   uart_rx_fsm dut (.CLK(clk), .RST(rst), .bus(bus));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   // Answers the checkers give in the cycle after their strobe.
   logic strt_resp = 1'b0;
   logic par_resp  = 1'b0;
   logic stop_resp = 1'b0;

   // Monitor counters (only written by the monitor).
   int cyc = 0, stop_cyc = 0;
   int n_strt = 0, n_deser = 0, n_par = 0, n_stop = 0;
   int n_dv = 0, n_fe = 0, n_pe = 0, n_both = 0, n_wide = 0;
   int n_bad_edge = 0, n_bad_gap = 0, n_samp = 0, max_bit = 0;
   logic [6:0] prev_vec = 7'd0;

   always @(negedge clk) begin
      logic [6:0] vec;
      int h2;
      vec = {bus.strt_chk_en, bus.deser_en, bus.par_chk_en, bus.stop_chk_en,
             bus.data_valid, bus.frame_err, bus.parity_err};
      h2  = int'(bus.Prescale) / 2 + 2;
      cyc++;
      if ((vec & prev_vec) != 7'd0) n_wide++;
      prev_vec = vec;
      if (bus.dat_samp_en) n_samp++;
      if (int'(bus.bit_cnt) > max_bit) max_bit = int'(bus.bit_cnt);
      if (bus.strt_chk_en) n_strt++;
      if (bus.deser_en)    n_deser++;
      if (bus.par_chk_en)  n_par++;
      if (bus.stop_chk_en) begin n_stop++; stop_cyc = cyc; end
      if ((bus.strt_chk_en || bus.deser_en || bus.par_chk_en || bus.stop_chk_en)
          && int'(bus.edge_cnt) != h2) n_bad_edge++;
      if (bus.data_valid) n_dv++;
      if (bus.frame_err)  n_fe++;
      if (bus.parity_err) n_pe++;
      if (bus.data_valid && bus.frame_err) n_both++;
      if ((bus.data_valid || bus.frame_err || bus.parity_err) && (cyc - stop_cyc) != 2)
         n_bad_gap++;
   end

   // Checker model: result valid for exactly the cycle after the strobe; stp_err idles at 1.
   initial begin
      bus.strt_glitch = 1'b0;
      bus.par_err     = 1'b0;
      bus.stp_err     = 1'b1;
      forever begin
         @(negedge clk);
         if (bus.strt_chk_en || bus.par_chk_en || bus.stop_chk_en) begin
            logic s, p, t;
            s = bus.strt_chk_en; p = bus.par_chk_en; t = bus.stop_chk_en;
            @(posedge clk); #1;
            if (s) bus.strt_glitch = strt_resp;
            if (p) bus.par_err     = par_resp;
            if (t) bus.stp_err     = stop_resp;
            @(posedge clk); #1;
            bus.strt_glitch = 1'b0;
            bus.par_err     = 1'b0;
            bus.stp_err     = 1'b1;
         end
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic send_frame(input logic [7:0] d, input logic with_par, input int p,
                             input int stop_len);
      bus.RX_IN = 1'b0;
      tick(p);
      for (int i = 0; i < 8; i++) begin
         bus.RX_IN = d[i];
         tick(p);
      end
      if (with_par) begin
         bus.RX_IN = ^d;
         tick(p);
      end
      bus.RX_IN = 1'b1;
      tick(stop_len);
   endtask

   int b_deser, b_strt, b_par, b_stop, b_dv, b_fe, b_pe, b_samp;
   task automatic snap();
      b_deser = n_deser; b_strt = n_strt; b_par = n_par; b_stop = n_stop;
      b_dv = n_dv; b_fe = n_fe; b_pe = n_pe; b_samp = n_samp;
   endtask

   task automatic check_frame(input string tag, input int e_strt, input int e_deser,
                              input int e_par, input int e_stop, input int e_dv,
                              input int e_fe, input int e_pe, input int e_samp);
      chk({tag, ".strt"},  n_strt  - b_strt,  e_strt);
      chk({tag, ".deser"}, n_deser - b_deser, e_deser);
      chk({tag, ".par"},   n_par   - b_par,   e_par);
      chk({tag, ".stop"},  n_stop  - b_stop,  e_stop);
      chk({tag, ".dv"},    n_dv    - b_dv,    e_dv);
      chk({tag, ".fe"},    n_fe    - b_fe,    e_fe);
      chk({tag, ".pe"},    n_pe    - b_pe,    e_pe);
      chk({tag, ".samp"},  n_samp  - b_samp,  e_samp);
      chk({tag, ".idle_edge"}, bus.edge_cnt, 0);
      chk({tag, ".idle_samp"}, bus.dat_samp_en, 0);
   endtask

   initial begin
      logic found;
      rst          = 1'b0;
      bus.RX_IN    = 1'b1;
      bus.PAR_EN   = 1'b0;
      bus.Prescale = 6'd8;
      tick(3);
      chk("rst.outs", {bus.edge_cnt, bus.bit_cnt, bus.dat_samp_en, bus.strt_chk_en,
                       bus.deser_en, bus.par_chk_en, bus.stop_chk_en, bus.data_valid,
                       bus.frame_err, bus.parity_err}, 0);
      rst = 1'b1;
      tick(3);
      chk("post_rst.idle", {bus.edge_cnt, bus.bit_cnt, bus.dat_samp_en}, 0);

      // Prescale 8, no parity, good stop: 8+64+8 sampling cycles.
      stop_resp = 1'b0;
      snap();
      send_frame(8'h55, 1'b0, 8, 8);
      tick(10);
      check_frame("p8", 1, 8, 0, 1, 1, 0, 0, 80);
      chk("p8.max_bit", max_bit, 7);

      // Prescale 16 with parity error latched, then a clean parity frame.
      bus.Prescale = 6'd16; bus.PAR_EN = 1'b1; par_resp = 1'b1;
      snap();
      send_frame(8'hA3, 1'b1, 16, 16);
      tick(10);
      check_frame("p16_perr", 1, 8, 1, 1, 0, 0, 1, 172);
      par_resp = 1'b0;
      snap();
      send_frame(8'h3C, 1'b1, 16, 16);
      tick(10);
      check_frame("p16_pok", 1, 8, 1, 1, 1, 0, 0, 172);

      // Prescale 32: stop sampled only at edge 19.
      bus.Prescale = 6'd32; bus.PAR_EN = 1'b0; stop_resp = 1'b0;
      snap();
      send_frame(8'hF0, 1'b0, 32, 32);
      tick(10);
      check_frame("p32_ok", 1, 8, 0, 1, 1, 0, 0, 308);
      stop_resp = 1'b1;
      snap();
      send_frame(8'h0F, 1'b0, 32, 32);
      tick(10);
      check_frame("p32_ferr", 1, 8, 0, 1, 0, 1, 0, 308);
      stop_resp = 1'b0;

      // Start glitch: abort at START edge 11, 12 sampling cycles.
      bus.Prescale = 6'd16; strt_resp = 1'b1;
      snap();
      bus.RX_IN = 1'b0;
      tick(4);
      bus.RX_IN = 1'b1;
      tick(30);
      check_frame("glitch", 1, 0, 0, 0, 0, 0, 0, 12);
      strt_resp = 1'b0;

      // Back-to-back: second start bit lands on the IDLE-return cycle.
      snap();
      send_frame(8'h12, 1'b0, 16, 13);
      send_frame(8'h34, 1'b0, 16, 16);
      tick(10);
      check_frame("b2b", 2, 16, 0, 2, 2, 0, 0, 312);

      // Reset mid-frame at bit 4 of the data.
      bus.RX_IN = 1'b0;
      tick(16);
      bus.RX_IN = 1'b1;
      found = 1'b0;
      for (int i = 0; i < 200 && !found; i++) begin
         if (bus.bit_cnt == 4'd4) found = 1'b1;
         else tick(1);
      end
      chk("rst_mid.reach_bit4", found, 1);
      #3 rst = 1'b0;
      #1;
      chk("rst_mid.outs", {bus.edge_cnt, bus.bit_cnt, bus.dat_samp_en, bus.strt_chk_en,
                           bus.deser_en, bus.par_chk_en, bus.stop_chk_en, bus.data_valid,
                           bus.frame_err, bus.parity_err}, 0);
      tick(2);
      rst = 1'b1;
      snap();
      tick(200);
      check_frame("rst_mid.after", 0, 0, 0, 0, 0, 0, 0, 0);

      chk("never_dv_and_fe", n_both, 0);
      chk("strobe_width", n_wide, 0);
      chk("strobe_edge", n_bad_edge, 0);
      chk("verdict_gap", n_bad_gap, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
